port_arbiter: RTL

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter_pkg.sv | 44 ++++
 rtl/port_arbiter_slot.sv | 46 ++++
 rtl/port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/port_arbiter_pkg.sv
// Shared node types: grant-source and FSM state encodings plus the round-robin
// port picker used by the arbiter.
package port_arbiter_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_LEFT  = 2'b01,
    SRC_RIGHT = 2'b10,
    SRC_SELF  = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OFFER = 2'b01,
    ST_BUSY  = 2'b10
  } state_e;

  localparam logic [1:0] IDX_LEFT  = 2'd0;
  localparam logic [1:0] IDX_RIGHT = 2'd1;
  localparam logic [1:0] IDX_SELF  = 2'd2;

  // First pending port strictly after 'last' in left->right->self order.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    idx     = last;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == IDX_SELF) ? IDX_LEFT : idx + 2'd1;
      if (pend[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic src_e idx_to_src(input logic [1:0] idx);
    return src_e'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/port_arbiter_slot.sv
// One holding slot: captures an instruction when empty (or being freed this
// cycle), otherwise flags the request as a drop.
module port_slot
  import port_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          clear_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic [DW-1:0] data_o,
  output logic          drop_o
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          capture;

  always_comb begin
    capture = req_i && (!full_q || clear_i);
    full_d  = full_q;
    data_d  = data_q;
    if (capture) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign drop_o = req_i && full_q && !clear_i && !reset;
  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/port_arbiter.sv
// Three-port instruction arbiter: per-port holding slots feed a round-robin
// IDLE/OFFER/BUSY grant FSM; overflowing requests are counted as drops.
module port_arbiter
  import port_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req_left,
  input  logic          req_right,
  input  logic          req_self,
  input  logic [DW-1:0] data_left,
  input  logic [DW-1:0] data_right,
  input  logic [DW-1:0] data_self,
  input  logic          grant_ack,
  input  logic          ctrl_done,
  output logic          grant_valid,
  output logic [DW-1:0] grant_data,
  output logic [1:0]    grant_src,
  output logic [2:0]    pending,
  output logic          busy,
  output logic [7:0]    drop_cnt,
  output logic [1:0]    state_o
);

  logic [2:0]    req_vec, full_vec, drop_vec, clear_vec;
  logic [DW-1:0] din    [3];
  logic [DW-1:0] slot_q [3];

  state_e        state_q, state_d;
  logic          grant_valid_q, grant_valid_d;
  logic [DW-1:0] grant_data_q, grant_data_d;
  src_e          grant_src_q, grant_src_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [8:0]    drop_sum;
  logic [1:0]    pick;
  logic [DW-1:0] pick_data;

  assign req_vec = {req_self, req_right, req_left};
  assign din[0]  = data_left;
  assign din[1]  = data_right;
  assign din[2]  = data_self;

  for (genvar g = 0; g < 3; g++) begin : g_slot
    port_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .req_i   (req_vec[g]),
      .clear_i (clear_vec[g]),
      .data_i  (din[g]),
      .full_o  (full_vec[g]),
      .data_o  (slot_q[g]),
      .drop_o  (drop_vec[g])
    );
  end

  // Decision uses registered full flags, so a same-cycle capture is never granted.
  always_comb begin
    pick = rr_pick(full_vec, last_q);
    case (pick)
      IDX_LEFT:  pick_data = slot_q[0];
      IDX_RIGHT: pick_data = slot_q[1];
      default:   pick_data = slot_q[2];
    endcase
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 9'(drop_vec[0]) + 9'(drop_vec[1]) + 9'(drop_vec[2]);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_data_q  <= '0;
      grant_src_q   <= SRC_NONE;
      sel_q         <= IDX_LEFT;
      last_q        <= IDX_SELF;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_data_q  <= grant_data_d;
      grant_src_q   <= grant_src_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|full_vec) state_d = ST_OFFER;
      ST_OFFER: if (grant_ack) state_d = ST_BUSY;
      ST_BUSY:  if (ctrl_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_data_d  = grant_data_q;
    grant_src_d   = grant_src_q;
    sel_d         = sel_q;
    last_d        = last_q;
    clear_vec     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|full_vec) begin
          grant_valid_d = 1'b1;
          grant_data_d  = pick_data;
          grant_src_d   = idx_to_src(pick);
          sel_d         = pick;
        end
      end
      ST_OFFER: begin
        if (grant_ack) begin
          clear_vec[sel_q] = !reset;
          grant_valid_d    = 1'b0;
          grant_data_d     = '0;
          grant_src_d      = SRC_NONE;
          last_d           = sel_q;
        end
      end
      default: ;
    endcase
  end

  assign grant_valid = grant_valid_q;
  assign grant_data  = grant_data_q;
  assign grant_src   = grant_src_q;
  assign pending     = full_vec;
  assign busy        = (state_q != ST_IDLE);
  assign drop_cnt    = drop_cnt_q;
  assign state_o     = state_q;

endmodule
